sysid_probe: RTL and testbench
==============================

# sysid_probe

Avalon-MM master sequencer for the system-ID slave: after reset it reads ID word (address 0) and timestamp word (address 1), compares both against build-time expected values, and publishes captured words plus sticky match/timeout status. Sits beside the Nios/SOPC fabric on the system clock so board logic (LED, LT24 init gating) can refuse to run on a mismatched bitstream/software pair. One read outstanding at a time; zero read latency, with waitrequest honoured.

## Interface
- EXPECTED_ID, 32'd21573, expected word at address 0
- EXPECTED_TS, 32'd1461100872, expected word at address 1
- TIMEOUT_CYCLES, 255, max waitrequest cycles per read (1..65535)
- RECHECK_PERIOD, 50_000_000, cycles spent in DONE before auto re-check (used only with macro)

- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to re-run the check
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- busy  out  1  sequence in progress
- done  out  1  sequence finished (pass, fail or timeout)
- id_match  out  1  id_value == EXPECTED_ID
- ts_match  out  1  ts_value == EXPECTED_TS
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES

## Operation
- States: S_IDLE, S_RD_ID, S_RD_TS, S_DONE. Reset state S_IDLE.
- S_IDLE -> S_RD_ID unconditionally on first edge after reset release (auto-start).
- S_RD_ID: avm_read=1, avm_address=0. On edge with !avm_waitrequest: id_value<=avm_readdata, id_match<=compare, wait counter cleared, -> S_RD_TS.
- S_RD_TS: avm_read=1, avm_address=1. On accept: ts_value, ts_match captured, -> S_DONE.
- Wait counter (16 bit) increments each cycle in a read state with avm_waitrequest=1; when it equals TIMEOUT_CYCLES: timeout_err<=1, id_match<=0, ts_match<=0, -> S_DONE; values not yet captured keep prior contents.
- S_DONE: done=1, avm_read=0. start=1 -> S_RD_ID, clearing done, id_match, ts_match, timeout_err, wait counter (id_value/ts_value retained until overwritten).
- start in S_RD_ID/S_RD_TS ignored; start in S_IDLE impossible to observe (one cycle).
- Accept and timeout on same edge: accept wins.
- Compare is full 32-bit equality; no masking.

## Timing
- All outputs registered except avm_read/avm_address, decoded directly from state register (glitch-free, no combinational path from inputs).
- Reset values: avm_read 0, avm_address 0, id_value 0, ts_value 0, busy 0, done 0, id_match 0, ts_match 0, timeout_err 0.
- busy=1 exactly while in S_RD_ID or S_RD_TS.
- With waitrequest tied low: reset release edge E0 -> S_RD_ID; E1 captures ID; E2 captures TS, done=1 after E2. Total 3 edges; each waitrequest cycle adds one.
- start to done: 3 edges with no stall.
- Timeout path: done rises on edge where counter reaches TIMEOUT_CYCLES.
- Reset mid-read: avm_read drops immediately (async), all status cleared, sequence restarts from S_IDLE.

## Configuration
- SYSID_PERIODIC_CHECK_EN defined: 32-bit period counter runs in S_DONE, cleared on entry; on reaching RECHECK_PERIOD-1 acts as start (same clearing). Explicit start also honoured and resets period counter.
- Undefined: no period counter; S_DONE held until start.

## Test plan
- Waitrequest 0, slave returns 21573/1461100872 -> after 3 edges done=1, id_match=1, ts_match=1, timeout_err=0, busy low.
- Slave returns 0x00005446 at address 0 -> id_match=0, ts_match=1, id_value=0x00005446.
- Waitrequest high 4 cycles per read -> done after 11 edges, both matches 1, avm_address held stable while stalled.
- Waitrequest stuck high, TIMEOUT_CYCLES=8 -> done 9 edges after reset, timeout_err=1, matches 0, avm_read low after.
- start pulse during S_RD_TS -> ignored; start in S_DONE -> flags clear next edge, rerun passes; reset_n low mid-read -> avm_read 0 asynchronously, all outputs at reset values.
- Macro defined, RECHECK_PERIOD=20 -> busy re-asserts 20 cycles after done, repeats; undefined -> done held indefinitely.

Source files
------------

// File: rtl/sysid_probe.sv
// Reads the system-ID slave (ID word, then timestamp) after reset or on request and publishes
// sticky match/timeout status. Define SYSID_PERIODIC_CHECK_EN for periodic automatic re-checks.
module sysid_probe #(
  parameter logic [31:0] EXPECTED_ID    = 32'd21573,
  parameter logic [31:0] EXPECTED_TS    = 32'd1461100872,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_PERIOD = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("sysid_probe: TIMEOUT_CYCLES must be within 1..65535");
  end
  if (RECHECK_PERIOD < 1) begin : gen_bad_period
    $error("sysid_probe: RECHECK_PERIOD must be at least 1");
  end

  // Timeout fires on the edge where the wait counter would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRdId, StRdTs, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic        restart;

`ifdef SYSID_PERIODIC_CHECK_EN
  localparam logic [31:0] RecheckLast = 32'(RECHECK_PERIOD - 1);
  logic [31:0] period_cnt_q, period_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    restart    = 1'b0;
`ifdef SYSID_PERIODIC_CHECK_EN
    period_cnt_d = period_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        state_d    = StRdId;
        wait_cnt_d = '0;
      end
      StRdId, StRdTs: begin
        // A completed transfer always takes priority over the stall limit.
        if (!avm_waitrequest) begin
          wait_cnt_d = '0;
          if (state_q == StRdId) begin
            id_value_d = avm_readdata;
            id_match_d = (avm_readdata == EXPECTED_ID);
            state_d    = StRdTs;
          end else begin
            ts_value_d = avm_readdata;
            ts_match_d = (avm_readdata == EXPECTED_TS);
            state_d    = StDone;
          end
        end else if (wait_cnt_q == TimeoutLast) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          timeout_d  = 1'b1;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          state_d    = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDone: begin
        restart = start;
`ifdef SYSID_PERIODIC_CHECK_EN
        if (period_cnt_q == RecheckLast) begin
          restart = 1'b1;
        end else begin
          period_cnt_d = period_cnt_q + 32'd1;
        end
`endif
        if (restart) begin
          state_d    = StRdId;
          wait_cnt_d = '0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef SYSID_PERIODIC_CHECK_EN
    // Holding the counter at zero outside StDone makes every entry start a fresh period.
    if (state_q != StDone) begin
      period_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef SYSID_PERIODIC_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end
`endif

  // Bus strobes and phase flags decode straight from the state flops.
  assign avm_read    = (state_q == StRdId) || (state_q == StRdTs);
  assign avm_address = (state_q == StRdTs);
  assign busy        = avm_read;
  assign done        = (state_q == StDone);
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sysid_probe.sv
// Self-checking bench for sysid_probe: vector table of slave behaviours plus hand-written
// start/reset/re-check sequences, with expected outcomes queued on a scoreboard.
module tb_sysid_probe;

  localparam logic [31:0] GoodId = 32'd21573;
  localparam logic [31:0] GoodTs = 32'd1461100872;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] id_value, ts_value;
  logic        busy, done, id_match, ts_match, timeout_err;

  logic [31:0] id_word = GoodId;
  logic [31:0] ts_word = GoodTs;
  int          stall_len = 0;
  int          stall_cnt = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall;
    int          edges;
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];

  sysid_probe #(
    .TIMEOUT_CYCLES(8),
    .RECHECK_PERIOD(20)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .busy           (busy),
    .done           (done),
    .id_match       (id_match),
    .ts_match       (ts_match),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  // Slave model: stalls each read for stall_len cycles, zero-latency data.
  always_comb begin
    avm_waitrequest = (stall_cnt < stall_len);
    avm_readdata    = avm_address ? ts_word : id_word;
  end

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Runs from the edge that enters the read sequence until done, checking the bus each cycle.
  task automatic run_check(input int s, input int pulse_k);
    int   k;
    bit   seen;
    vec_t e;
    k = 0;
    seen = 0;
    while (!seen && k < 3000) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      start = (k == pulse_k);
      if (k == 1) begin
        chk("flags_clear_id", id_match, 0);
        chk("flags_clear_ts", ts_match, 0);
        chk("flags_clear_to", timeout_err, 0);
      end
      if (done) seen = 1;
      else begin
        chk("busy_run", busy, 1);
        chk("read_run", avm_read, 1);
        chk("addr_run", avm_address, (k <= s + 1) ? 0 : 1);
      end
    end
    start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      if (!seen) chk("done_never", 0, 1);
      else begin
        chk("edges", k, e.edges);
        chk("id_match", id_match, e.idm);
        chk("ts_match", ts_match, e.tsm);
        chk("timeout_err", timeout_err, e.to);
        chk("id_value", id_value, e.idv);
        chk("ts_value", ts_value, e.tsv);
        chk("busy_done", busy, 0);
        chk("read_done", avm_read, 0);
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] iw, input logic [31:0] tw, input int s,
                          input int ed, input logic im, input logic tm, input logic to,
                          input logic [31:0] iv, input logic [31:0] tv);
    vec_t e;
    e.id_word = iw; e.ts_word = tw; e.stall = s; e.edges = ed;
    e.idm = im; e.tsm = tm; e.to = to; e.idv = iv; e.tsv = tv;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t v;
    int   j;
    int   held;
    // id, ts, stall, edges, id_match, ts_match, timeout, id_value, ts_value
    vecs[0] = '{GoodId, GoodTs, 0, 3, 1, 1, 0, GoodId, GoodTs};
    vecs[1] = '{32'h0000_5446, GoodTs, 0, 3, 0, 1, 0, 32'h0000_5446, GoodTs};
    vecs[2] = '{GoodId, GoodTs, 4, 11, 1, 1, 0, GoodId, GoodTs};
    vecs[3] = '{GoodId, GoodTs, 1000, 9, 0, 0, 1, 32'h0, 32'h0};
    vecs[4] = '{GoodId, GoodTs ^ 32'h8000_0000, 1, 5, 1, 0, 0, GoodId, GoodTs ^ 32'h8000_0000};
    vecs[5] = '{GoodId, GoodTs, 7, 17, 1, 1, 0, GoodId, GoodTs};
    vecs[6] = '{32'h1234_5678, GoodTs, 8, 9, 0, 0, 1, 32'h0, 32'h0};

    #1;
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_id_value", id_value, 0);
    chk("rst_ts_value", ts_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id_match", id_match, 0);
    chk("rst_ts_match", ts_match, 0);
    chk("rst_timeout", timeout_err, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clock);
      reset_n = 1'b0;
      id_word = v.id_word;
      ts_word = v.ts_word;
      stall_len = v.stall;
      @(negedge clock);
      @(negedge clock);
      exp_q.push_back(v);
      reset_n = 1'b1;
      run_check(v.stall, 0);
    end

    // Start during the timestamp read is ignored.
    @(negedge clock);
    reset_n = 1'b0;
    id_word = GoodId; ts_word = GoodTs; stall_len = 2;
    @(negedge clock);
    push_exp(GoodId, GoodTs, 2, 7, 1, 1, 0, GoodId, GoodTs);
    reset_n = 1'b1;
    run_check(2, 4);
    repeat (5) @(negedge clock);
    chk("done_hold", done, 1);

    // Start from done reruns with flags cleared; the bad ID is now reported.
    stall_len = 0;
    id_word = 32'hDEAD_BEEF;
    push_exp(32'hDEAD_BEEF, GoodTs, 0, 3, 0, 1, 0, 32'hDEAD_BEEF, GoodTs);
    start = 1'b1;
    run_check(0, 0);

    // Reset in the middle of a stalled read drops the strobe at once.
    stall_len = 1000;
    id_word = GoodId;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_read_busy", avm_read, 1);
    chk("id_value_retained", id_value, 32'hDEAD_BEEF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_read", avm_read, 0);
    chk("async_busy", busy, 0);
    chk("async_id_value", id_value, 0);
    chk("async_ts_value", ts_value, 0);
    chk("async_ts_match", ts_match, 0);
    @(negedge clock);
    @(negedge clock);
    stall_len = 0;
    push_exp(GoodId, GoodTs, 0, 3, 1, 1, 0, GoodId, GoodTs);
    reset_n = 1'b1;
    run_check(0, 0);

`ifdef SYSID_PERIODIC_CHECK_EN
    for (int r = 0; r < 2; r++) begin
      j = 0;
      while (j < 40 && !busy) begin
        @(posedge clock);
        j++;
        @(negedge clock);
      end
      chk("recheck_delay", j, 20);
      push_exp(GoodId, GoodTs, 0, 2, 1, 1, 0, GoodId, GoodTs);
      run_check(0, 0);
    end
`else
    held = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done && !busy) held++;
    end
    chk("done_held", held, 60);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
